// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time IMEM loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Frame loader: length header, little-endian words into IMEM, XOR checksum;
// releases the CPU from reset only after a good frame.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    imem_loader_if.slave        i_stream,
    output logic                o_imem_we,
    output logic [ADDR_W-1:0]   o_imem_addr,
    output logic [31:0]         o_imem_wdata,
    output logic                o_cpu_rst_n,
    output logic                o_done,
    output logic                o_error,
    output logic [15:0]         o_words_loaded
);

    localparam logic [31:0] CAPACITY  = 32'd1 << ADDR_W;
    localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_in_ready;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_word_idx;
    logic [1:0]         r_byte_cnt;
    logic [23:0]        r_shift;
    logic [7:0]         r_xor;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic               r_cpu_rst_n;
    logic               r_done;
    logic               r_error;
    logic [15:0]        r_words_loaded;

    logic               w_accept;
    logic [LEN_W-1:0]   w_len_full;
    logic               w_last_word;

    // A start pulse in the same cycle as a valid byte wins; the byte is dropped.
    assign w_accept    = i_stream.in_valid && r_in_ready && !i_start;
    assign w_len_full  = {i_stream.in_data, r_len[7:0]};
    assign w_last_word = (r_byte_cnt == LAST_BYTE) && (r_word_idx == r_len - 16'd1);

    always_comb begin
        w_next = r_state;
        if (i_start) begin
            w_next = LEN_LO;
        end else begin
            case (r_state)
                LEN_LO: if (w_accept) w_next = LEN_HI;
                LEN_HI: begin
                    if (w_accept) begin
                        if (32'(w_len_full) > CAPACITY) w_next = ERROR;
                        else if (w_len_full == '0)      w_next = CHECK;
                        else                            w_next = DATA;
                    end
                end
                DATA:   if (w_accept && w_last_word) w_next = CHECK;
                CHECK: begin
                    if (w_accept) w_next = (i_stream.in_data == r_xor) ? DONE : ERROR;
                end
                default: w_next = r_state;
            endcase
        end
    end

    // Status outputs are registered from the next state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == LEN_LO) || (w_next == LEN_HI) ||
                           (w_next == DATA)   || (w_next == CHECK);
            r_done      <= (w_next == DONE);
            r_error     <= (w_next == ERROR);
            r_cpu_rst_n <= (w_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len          <= '0;
            r_word_idx     <= '0;
            r_byte_cnt     <= '0;
            r_shift        <= '0;
            r_xor          <= '0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_words_loaded <= '0;
        end else begin
            r_we <= 1'b0;
            if (i_start) begin
                r_word_idx     <= '0;
                r_byte_cnt     <= '0;
                r_xor          <= '0;
                r_words_loaded <= '0;
            end else if (w_accept) begin
                case (r_state)
                    LEN_LO: r_len[7:0]  <= i_stream.in_data;
                    LEN_HI: r_len[15:8] <= i_stream.in_data;
                    DATA: begin
                        r_xor <= r_xor ^ i_stream.in_data;
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_we           <= 1'b1;
                            r_addr         <= r_word_idx[ADDR_W-1:0];
                            r_wdata        <= {i_stream.in_data, r_shift};
                            r_word_idx     <= r_word_idx + 16'd1;
                            r_words_loaded <= r_words_loaded + 16'd1;
                            r_byte_cnt     <= '0;
                        end else begin
                            r_shift    <= {i_stream.in_data, r_shift[23:8]};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign i_stream.in_ready = r_in_ready;
    assign o_imem_we         = r_we;
    assign o_imem_addr       = r_addr;
    assign o_imem_wdata      = r_wdata;
    assign o_cpu_rst_n       = r_cpu_rst_n;
    assign o_done            = r_done;
    assign o_error           = r_error;
    assign o_words_loaded    = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: frames, checksum, limits, reset and restart.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imemWe;
    logic [7:0]  imemAddr;
    logic [31:0] imemWdata;
    logic        cpuRstN;
    logic        done;
    logic        error;
    logic [15:0] wordsLoaded;

    int nVec  = 0;
    int nMiss = 0;

    logic [31:0] frameWords [0:7];
    logic [7:0]  wrAddr [$];
    logic [31:0] wrData [$];

    imem_loader_if stream ();

    imem_loader #(.ADDR_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (start),
        .i_stream       (stream.slave),
        .o_imem_we      (imemWe),
        .o_imem_addr    (imemAddr),
        .o_imem_wdata   (imemWdata),
        .o_cpu_rst_n    (cpuRstN),
        .o_done         (done),
        .o_error        (error),
        .o_words_loaded (wordsLoaded)
    );

    always #5 clk = ~clk;

    // Record every IMEM write, sampled mid-cycle.
    always @(negedge clk) begin
        if (imemWe === 1'b1) begin
            wrAddr.push_back(imemAddr);
            wrData.push_back(imemWdata);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearLog();
        wrAddr.delete();
        wrData.delete();
    endtask

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic sendByte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            stream.in_valid = 1'b0;
            @(negedge clk);
        end
        stream.in_valid = 1'b1;
        stream.in_data  = b;
        t = 0;
        while (stream.in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            nVec++;
            nMiss++;
            $display("[TB] FAIL sendByte_timeout: in_ready=%b required 1", stream.in_ready);
        end else begin
            @(negedge clk);
        end
        stream.in_valid = 1'b0;
    endtask

    task automatic startPulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sendFrame(input logic [15:0] n, input int nSend, input logic [7:0] csum, input bit gaps);
        logic [31:0] wd;
        sendByte(n[7:0], 0);
        sendByte(n[15:8], 0);
        for (int i = 0; i < nSend; i++) begin
            wd = frameWords[i];
            for (int b = 0; b < 4; b++)
                sendByte(wd[8*b +: 8], gaps ? int'($urandom_range(0, 2)) : 0);
        end
        sendByte(csum, gaps ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic loadProgram();
        frameWords[0] = 32'h00A00093;
        frameWords[1] = 32'h01400113;
        frameWords[2] = 32'h002081B3;
        frameWords[3] = 32'h00302023;
        frameWords[4] = 32'h00002203;
        frameWords[5] = 32'h401202B3;
    endtask

    task automatic test_reset();
        nVec++; if (stream.in_ready !== 1'b0) begin nMiss++; $display("[TB] FAIL reset_in_ready: got %b want 0", stream.in_ready); end
        nVec++; if (imemWe !== 1'b0) begin nMiss++; $display("[TB] FAIL reset_imem_we: got %b want 0", imemWe); end
        nVec++; if (imemAddr !== 8'h00) begin nMiss++; $display("[TB] FAIL reset_imem_addr: got %h want 00", imemAddr); end
        nVec++; if (imemWdata !== 32'h0) begin nMiss++; $display("[TB] FAIL reset_imem_wdata: got %h want 0", imemWdata); end
        nVec++; if (cpuRstN !== 1'b0) begin nMiss++; $display("[TB] FAIL reset_cpu_rst_n: got %b want 0", cpuRstN); end
        nVec++; if (done !== 1'b0) begin nMiss++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        nVec++; if (error !== 1'b0) begin nMiss++; $display("[TB] FAIL reset_error: got %b want 0", error); end
        nVec++; if (wordsLoaded !== 16'd0) begin nMiss++; $display("[TB] FAIL reset_words_loaded: got %0d want 0", wordsLoaded); end
    endtask

    task automatic checkProgramLoaded(input string tag);
        nVec++; if (wrAddr.size() != 6) begin nMiss++; $display("[TB] FAIL %s_write_count: got %0d want 6", tag, wrAddr.size()); end
        for (int i = 0; i < 6; i++) begin
            nVec++;
            if (wrAddr[i] !== 8'(i) || wrData[i] !== frameWords[i]) begin
                nMiss++;
                $display("[TB] FAIL %s_write%0d: got addr %h data %h want addr %h data %h",
                         tag, i, wrAddr[i], wrData[i], 8'(i), frameWords[i]);
            end
        end
        nVec++; if (done !== 1'b1 || cpuRstN !== 1'b1 || error !== 1'b0) begin nMiss++; $display("[TB] FAIL %s_status: got done=%b cpu_rst_n=%b error=%b want 1 1 0", tag, done, cpuRstN, error); end
        nVec++; if (wordsLoaded !== 16'd6) begin nMiss++; $display("[TB] FAIL %s_words_loaded: got %0d want 6", tag, wordsLoaded); end
        nVec++; if (stream.in_ready !== 1'b0) begin nMiss++; $display("[TB] FAIL %s_ready_in_done: got %b want 0", tag, stream.in_ready); end
    endtask

    task automatic test_sample_program();
        loadProgram();
        clearLog();
        startPulse();
        nVec++; if (cpuRstN !== 1'b0 || stream.in_ready !== 1'b1) begin nMiss++; $display("[TB] FAIL prog_after_start: got cpu_rst_n=%b in_ready=%b want 0 1", cpuRstN, stream.in_ready); end
        sendFrame(16'd6, 6, 8'h83, 1'b0);
        checkProgramLoaded("prog");
    endtask

    task automatic test_bad_checksum();
        frameWords[0] = 32'hDEADBEEF;
        clearLog();
        startPulse();
        sendFrame(16'd1, 1, 8'h21, 1'b0);
        nVec++; if (wrAddr.size() != 1 || wrAddr[0] !== 8'h00 || wrData[0] !== 32'hDEADBEEF) begin nMiss++; $display("[TB] FAIL badsum_write: got n=%0d addr %h data %h want 1 00 deadbeef", wrAddr.size(), wrAddr[0], wrData[0]); end
        nVec++; if (error !== 1'b1 || done !== 1'b0 || cpuRstN !== 1'b0) begin nMiss++; $display("[TB] FAIL badsum_status: got error=%b done=%b cpu_rst_n=%b want 1 0 0", error, done, cpuRstN); end
        nVec++; if (stream.in_ready !== 1'b0) begin nMiss++; $display("[TB] FAIL badsum_ready: got %b want 0", stream.in_ready); end
        startPulse();
        nVec++; if (error !== 1'b0) begin nMiss++; $display("[TB] FAIL badsum_restart_error: got %b want 0", error); end
        sendFrame(16'd1, 1, 8'h22, 1'b0);
        nVec++; if (done !== 1'b1 || error !== 1'b0 || cpuRstN !== 1'b1 || wordsLoaded !== 16'd1) begin nMiss++; $display("[TB] FAIL goodsum_status: got done=%b error=%b cpu_rst_n=%b words=%0d want 1 0 1 1", done, error, cpuRstN, wordsLoaded); end
    endtask

    task automatic test_zero_length();
        clearLog();
        startPulse();
        sendFrame(16'd0, 0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        nVec++; if (wrAddr.size() != 0) begin nMiss++; $display("[TB] FAIL zero_len_writes: got %0d want 0", wrAddr.size()); end
        nVec++; if (done !== 1'b1 || wordsLoaded !== 16'd0) begin nMiss++; $display("[TB] FAIL zero_len_status: got done=%b words=%0d want 1 0", done, wordsLoaded); end
    endtask

    task automatic test_overflow();
        clearLog();
        startPulse();
        sendByte(8'h01, 0);
        sendByte(8'h01, 0);
        nVec++; if (error !== 1'b1 || done !== 1'b0) begin nMiss++; $display("[TB] FAIL overflow_error: got error=%b done=%b want 1 0", error, done); end
        nVec++; if (stream.in_ready !== 1'b0) begin nMiss++; $display("[TB] FAIL overflow_ready: got %b want 0", stream.in_ready); end
        // Keep offering payload; none of it may be taken.
        stream.in_valid = 1'b1;
        stream.in_data  = 8'h5A;
        repeat (8) @(negedge clk);
        stream.in_valid = 1'b0;
        nVec++; if (wrAddr.size() != 0 || wordsLoaded !== 16'd0 || error !== 1'b1) begin nMiss++; $display("[TB] FAIL overflow_no_payload: got writes=%0d words=%0d error=%b want 0 0 1", wrAddr.size(), wordsLoaded, error); end
    endtask

    task automatic test_gaps();
        loadProgram();
        clearLog();
        startPulse();
        sendFrame(16'd6, 6, 8'h83, 1'b1);
        checkProgramLoaded("gaps");
    endtask

    task automatic test_reset_mid();
        logic [31:0] wd;
        loadProgram();
        clearLog();
        startPulse();
        sendByte(8'h06, 0);
        sendByte(8'h00, 0);
        for (int i = 0; i < 14; i++) begin
            wd = frameWords[i / 4];
            sendByte(wd[8*(i%4) +: 8], 0);
        end
        nVec++; if (wrAddr.size() != 3) begin nMiss++; $display("[TB] FAIL midreset_pre_writes: got %0d want 3", wrAddr.size()); end
        rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frameWords[0] = 32'hDEADBEEF;
        clearLog();
        startPulse();
        sendFrame(16'd1, 1, 8'h22, 1'b0);
        nVec++; if (wrAddr.size() != 1 || wrAddr[0] !== 8'h00 || wrData[0] !== 32'hDEADBEEF) begin nMiss++; $display("[TB] FAIL midreset_reload: got n=%0d addr %h data %h want 1 00 deadbeef", wrAddr.size(), wrAddr[0], wrData[0]); end
        nVec++; if (done !== 1'b1 || wordsLoaded !== 16'd1) begin nMiss++; $display("[TB] FAIL midreset_done: got done=%b words=%0d want 1 1", done, wordsLoaded); end
    endtask

    task automatic test_restart_in_done();
        nVec++; if (done !== 1'b1) begin nMiss++; $display("[TB] FAIL restart_precondition: got done=%b want 1", done); end
        frameWords[0] = 32'h12345678;
        clearLog();
        // Start coincides with a valid byte; that byte must be dropped.
        stream.in_valid = 1'b1;
        stream.in_data  = 8'hFF;
        startPulse();
        stream.in_valid = 1'b0;
        nVec++; if (cpuRstN !== 1'b0 || done !== 1'b0 || wordsLoaded !== 16'd0 || stream.in_ready !== 1'b1) begin nMiss++; $display("[TB] FAIL restart_clear: got cpu_rst_n=%b done=%b words=%0d in_ready=%b want 0 0 0 1", cpuRstN, done, wordsLoaded, stream.in_ready); end
        // 78^56^34^12 = 08
        sendFrame(16'd1, 1, 8'h08, 1'b0);
        nVec++; if (wrAddr.size() != 1 || wrAddr[0] !== 8'h00 || wrData[0] !== 32'h12345678) begin nMiss++; $display("[TB] FAIL restart_write: got n=%0d addr %h data %h want 1 00 12345678", wrAddr.size(), wrAddr[0], wrData[0]); end
        nVec++; if (done !== 1'b1 || error !== 1'b0 || cpuRstN !== 1'b1) begin nMiss++; $display("[TB] FAIL restart_done: got done=%b error=%b cpu_rst_n=%b want 1 0 1", done, error, cpuRstN); end
    endtask

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        stream.in_valid = 1'b0;
        stream.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();

        test_sample_program();
        test_bad_checksum();
        test_zero_length();
        test_overflow();
        test_gaps();
        test_restart_in_done();
        test_reset_mid();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle CPU's instruction memory. It accepts a framed byte stream over a valid/ready handshake (length header, little-endian instruction words, XOR checksum), assembles the bytes into 32-bit words and writes them to consecutive IMEM word addresses from 0. It holds the CPU in reset until a frame completes with a good checksum. This replaces testbench hierarchical pokes into IMEM banks with a synthesizable load path.

## Interface
- ADDR_W, 8, IMEM word-address width; capacity 2^ADDR_W words
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins or restarts a load
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  one-cycle word write strobe; all four byte banks written
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  assembled word; byte 0 of the stream in [7:0]
- cpu_rst_n  out  1  CPU reset, active-low; high only in DONE
- done  out  1  frame loaded, checksum good
- error  out  1  length overflow or checksum mismatch
- words_loaded  out  16  words written in current or last frame

## Operation
- Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4·N payload bytes, 1 checksum byte = XOR of all payload bytes (header excluded).
- States: IDLE → LEN_LO → LEN_HI → DATA → CHECK → DONE; any → ERROR as below.
- IDLE: in_ready=0; start → LEN_LO.
- LEN_LO/LEN_HI: accept one byte each. After LEN_HI: N > 2^ADDR_W → ERROR; N = 0 → CHECK; else DATA.
- DATA: byte counter 0..3 shifts bytes into word register little-endian; running XOR updated per byte. On 4th byte: write issued, word index increments, words_loaded increments; after word N-1 → CHECK.
- CHECK: accept one byte; equals running XOR → DONE, else ERROR.
- DONE: done=1, cpu_rst_n=1, in_ready=0. ERROR: error=1, cpu_rst_n=0, in_ready=0.
- start in any non-IDLE state: restart at LEN_LO; clear done, error, XOR, byte/word counters, words_loaded; drive cpu_rst_n=0. IMEM contents are not rolled back.
- Bytes presented while in_ready=0 are ignored, not queued.

## Timing
- Reset values: state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, done=0, error=0, words_loaded=0.
- Byte accepted at a rising edge where in_valid && in_ready.
- in_ready is a registered function of state; high in LEN_LO, LEN_HI, DATA, CHECK. No stall cycles: one byte/cycle sustained.
- Write latency: imem_we, imem_addr, imem_wdata registered at the edge accepting a word's 4th byte; imem_we high exactly the following cycle.
- done/cpu_rst_n rise the cycle after checksum acceptance; error rises the cycle after the failing byte.
- start and in_valid in the same cycle: start wins; the byte is dropped.
- Reset mid-frame: immediate return to reset values, partial word discarded.

## Structure
- Package imem_loader_pkg: state enum (IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR), LEN_W=16, BYTES_PER_WORD=4.
- Single module; no sub-module. Top-level CPU wrapper connects imem_we/addr/wdata to the IMEM write port and cpu_rst_n to the CPU reset.

## Test plan
- Load the six-word CPU sample program (00A00093, 01400113, 002081B3, 00302023, 00002203, 401202B3), N=6, checksum 0x83 → six imem_we pulses at addr 0..5 with those words, done=1, words_loaded=6; CPU then yields x3=30, x5=20, mem[0]=0x0000001E.
- N=1, bytes EF BE AD DE, checksum 0x21 → word 0xDEADBEEF at addr 0, then error=1, done=0, cpu_rst_n=0; correct checksum 0x22 → done=1.
- N=0, checksum 0x00 → no imem_we, done=1; N=0x0101 with ADDR_W=8 → error after LEN_HI, no payload accepted.
- in_valid toggled randomly during payload → identical IMEM writes and checksum result as gap-free stream.
- rst_n low after 2 payload bytes of word 3 → all outputs at reset values, in_ready=0; restart loads from addr 0.
- start pulsed in DONE → cpu_rst_n falls next cycle, done=0, words_loaded=0, new frame accepted.
